wb_port_arbiter: RTL

- Shares the single register-file write port between the in-order pipeline write-back stage and a multi-cycle unit (mul/div) that finishes out of band.
- The pipeline always wins the port. Multi-cycle results wait in a small FIFO and drain into free write slots.
- A starvation counter forces a pipeline bubble so queued results cannot wait forever.
- Sits between the write-back mux output and the register file write inputs.

---
 rtl/wb_port_arbiter_pkg.sv | 15 +
 rtl/wb_fifo2.sv | 76 +++++++
 rtl/wb_port_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared constants for the write-back port arbiter: FSM encodings, width defaults
// and the queue-count width.
package wb_port_arbiter_pkg;

  localparam int WB_DW = 32;
  localparam int WB_AW = 5;
  localparam int WB_CW = 2;

  typedef enum logic [1:0] {
    WB_IDLE  = 2'd0,
    WB_DRAIN = 2'd1,
    WB_FORCE = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_fifo2.sv
// Two-entry {rn,data} FIFO holding multi-cycle results until a write slot is free.
// With WB_QHAZARD_EN defined it also exposes both entries' rn and valid bits.
module wb_fifo2
  import wb_port_arbiter_pkg::*;
#(
  parameter int DW = WB_DW,
  parameter int AW = WB_AW
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             push,
  input  logic [AW-1:0]    push_rn,
  input  logic [DW-1:0]    push_data,
  input  logic             pop,
  output logic [AW-1:0]    head_rn,
  output logic [DW-1:0]    head_data,
  output logic             full,
  output logic             empty,
  output logic [WB_CW-1:0] count
`ifdef WB_QHAZARD_EN
  ,
  output logic [AW-1:0]    rn0,
  output logic [AW-1:0]    rn1,
  output logic [1:0]       vld
`endif
);

  logic [AW-1:0]    rn_mem   [2];
  logic [DW-1:0]    data_mem [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [WB_CW-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign full      = (cnt == 2'd2);
  assign empty     = (cnt == 2'd0);
  assign count     = cnt;
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_rn   = rn_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt    <= '0;
      for (int i = 0; i < 2; i++) begin
        rn_mem[i]   <= '0;
        data_mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        rn_mem[wr_ptr]   <= push_rn;
        data_mem[wr_ptr] <= push_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

`ifdef WB_QHAZARD_EN
  assign rn0 = rn_mem[0];
  assign rn1 = rn_mem[1];
  // Entry i is live if the queue is full, or holds one entry sitting at slot i.
  assign vld[0] = full || (!empty && !rd_ptr);
  assign vld[1] = full || (!empty && rd_ptr);
`endif

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the pipeline (always wins) and a
// queued multi-cycle unit; optional decode hazard output under WB_QHAZARD_EN.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DW         = WB_DW,
  parameter int AW         = WB_AW,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             pipe_wreg,
  input  logic [AW-1:0]    pipe_rn,
  input  logic [DW-1:0]    pipe_wdi,
  input  logic             mc_valid,
  output logic             mc_ready,
  input  logic [AW-1:0]    mc_rn,
  input  logic [DW-1:0]    mc_data,
  output logic             rf_we,
  output logic [AW-1:0]    rf_wn,
  output logic [DW-1:0]    rf_d,
  output logic             pipe_stall,
  output logic [WB_CW-1:0] q_count,
  output logic [1:0]       fsm_state
`ifdef WB_QHAZARD_EN
  ,
  input  logic [AW-1:0]    id_rs,
  input  logic [AW-1:0]    id_rt,
  output logic             q_hazard
`endif
);

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  // Handshake: mc_valid/mc_rn/mc_data are held stable by the producer until
  // mc_ready; a transfer happens on any edge where both mc_valid and mc_ready are 1.
  wb_state_e        state, state_n;
  logic [3:0]       starve, starve_n;
  logic             live, pop, accept, push;
  logic             full, empty;
  logic [AW-1:0]    head_rn;
  logic [DW-1:0]    head_data;
  logic [WB_CW-1:0] count;

`ifdef WB_QHAZARD_EN
  logic [AW-1:0] rn0, rn1;
  logic [1:0]    vld;
`endif

  assign live     = pipe_wreg && (pipe_rn != '0);
  assign mc_ready = clrn && !full;
  assign accept   = mc_valid && mc_ready;
  assign push     = accept && (mc_rn != '0);
  assign pop      = clrn && !live && !empty;
  assign q_count  = count;
  assign fsm_state = state;

  wb_fifo2 #(.DW(DW), .AW(AW)) u_fifo (
    .clk       (clk),
    .clrn      (clrn),
    .push      (push),
    .push_rn   (mc_rn),
    .push_data (mc_data),
    .pop       (pop),
    .head_rn   (head_rn),
    .head_data (head_data),
    .full      (full),
    .empty     (empty),
    .count     (count)
`ifdef WB_QHAZARD_EN
    ,
    .rn0       (rn0),
    .rn1       (rn1),
    .vld       (vld)
`endif
  );

  always_comb begin
    rf_we = 1'b0;
    rf_wn = '0;
    rf_d  = '0;
    if (clrn) begin
      if (live) begin
        rf_we = 1'b1;
        rf_wn = pipe_rn;
        rf_d  = pipe_wdi;
      end else if (!empty) begin
        rf_we = 1'b1;
        rf_wn = head_rn;
        rf_d  = head_data;
      end
    end
  end

  // A stall is pointless once the bubble it asked for drains the last entry.
  assign pipe_stall = clrn && (state == WB_FORCE) &&
                      !(pop && (count == 2'd1) && !push);

  always_comb begin
    state_n  = state;
    starve_n = starve;
    case (state)
      WB_IDLE: begin
        starve_n = '0;
        if (push) state_n = WB_DRAIN;
      end
      WB_DRAIN: begin
        if (pop) begin
          starve_n = '0;
          if ((count == 2'd1) && !push) state_n = WB_IDLE;
        end else if (live) begin
          starve_n = starve + 4'd1;
          if (starve + 4'd1 >= SMAX) state_n = WB_FORCE;
        end
      end
      WB_FORCE: begin
        if (pop) begin
          starve_n = '0;
          state_n  = ((count == 2'd1) && !push) ? WB_IDLE : WB_DRAIN;
        end
      end
      default: begin
        state_n  = WB_IDLE;
        starve_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state  <= WB_IDLE;
      starve <= '0;
    end else begin
      state  <= state_n;
      starve <= starve_n;
    end
  end

`ifdef WB_QHAZARD_EN
  function automatic logic rn_hit(input logic [AW-1:0] rn, input logic [AW-1:0] rs,
                                  input logic [AW-1:0] rt);
    return (rn != '0) && ((rn == rs) || (rn == rt));
  endfunction

  assign q_hazard = (vld[0] && rn_hit(rn0, id_rs, id_rt)) ||
                    (vld[1] && rn_hit(rn1, id_rs, id_rt)) ||
                    (accept && rn_hit(mc_rn, id_rs, id_rt));
`endif

endmodule
